vme_master_sequencer: RTL and testbench

- Parametrised VME master data-transfer engine for the k30p CPU board. It is the next generation of the board's fixed-width VME transfer logic.
- Converts a decoded 68030 bus cycle (A16/A24/A40 request) into a VME strobe sequence with correct address modifier, data strobes and LWORD. Returns DSACK sized to the configured port width.
- Adds a bus-timeout watchdog that raises BERR, VME-compliant strobe recovery, and transceiver enable/direction sequencing.
- Sits between address decode/arbitration and the CPU DSACK/BERR merge logic.

---
 rtl/vme_master_sequencer_pkg.sv | 41 ++++
 rtl/vme_signal_sync.sv | 28 ++
 rtl/vme_master_sequencer.sv | 179 +++++++++++++++++
 tb/tb_vme_master_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_master_sequencer_pkg.sv
// Shared definitions for the VME master sequencer: AM codes, strobe levels,
// DSACK encodings and the sequencer state enum.
package vme_defs;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam logic [5:0] AM_A16_SUP      = 6'h2D;
    localparam logic [5:0] AM_A16_USR      = 6'h29;
    localparam logic [5:0] AM_A24_SUP_DATA = 6'h3D;
    localparam logic [5:0] AM_A24_SUP_PROG = 6'h3E;
    localparam logic [5:0] AM_A24_USR_DATA = 6'h39;
    localparam logic [5:0] AM_A24_USR_PROG = 6'h3A;
    localparam logic [5:0] AM_A40          = 6'h34;
    localparam logic [5:0] AM_IDLE         = 6'h3F;

    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    typedef enum logic [2:0] {
        IDLE, ADDR, STROBE, WAIT_ACK, ACK, ERROR, RECOVER
    } state_e;

    // AM code for the selected space; A16 wins over A24, A24 over A40.
    function automatic logic [5:0] am_code(input logic sel_a16, input logic sel_a24,
                                           input logic [2:0] fc);
        logic sup;
        logic prog;
        sup  = fc[2];
        prog = (fc[1:0] == 2'b10);
        if (sel_a16)
            return sup ? AM_A16_SUP : AM_A16_USR;
        else if (sel_a24)
            return sup ? (prog ? AM_A24_SUP_PROG : AM_A24_SUP_DATA)
                       : (prog ? AM_A24_USR_PROG : AM_A24_USR_DATA);
        else
            return AM_A40;
    endfunction

endpackage

// File: rtl/vme_signal_sync.sv
// Multi-stage synchroniser for an asynchronous active-low VME input.
// Resets to the inactive (high) level so no spurious ack is seen after reset.
module vme_signal_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at bit 0; the oldest sample drives q.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser flops, cleared to inactive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/vme_master_sequencer.sv
// VME master data-transfer sequencer: turns a decoded 68030 cycle into a VME
// strobe sequence, returns DSACK sized to the port, and raises BERR on slave
// error or on a local timeout.
module vme_master_sequencer
    import vme_defs::*;
#(
    parameter int PORT_WIDTH  = 16,
    parameter int AS_SETUP    = 2,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       request_vme_a16,
    input  logic       request_vme_a24,
    input  logic       request_vme_a40,
    input  logic       bus_acquired,
    input  logic       cpu_as,
    input  logic       cpu_ds,
    input  logic       cpu_write,
    input  logic [1:0] cpu_siz,
    input  logic [1:0] cpu_address,
    input  logic [2:0] cpu_fc,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr,
    output logic       vme_as,
    output logic [1:0] vme_ds,
    output logic       vme_lword,
    output logic       vme_write,
    output logic [5:0] vme_address_mod,
    input  logic       vme_dtack,
    input  logic       vme_berr,
    output logic       busy,
    output logic       addr_oe,
    output logic       data_oe,
    output logic       data_dir
);

    localparam logic [2:0]  SETUP_LOAD = 3'(AS_SETUP);
    localparam logic [15:0] TMO_LOAD   = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic [5:0]  am_q, am_d;
    logic        write_q, write_d;
    logic        lword_q, lword_d;
    logic [1:0]  ds_q, ds_d;
    logic        dir_q, dir_d;
    logic [2:0]  setup_q, setup_d;
    logic [15:0] tmo_q, tmo_d;

    logic dtack_s;
    logic berr_s;
    logic req_any;
    logic lword_sel;
    logic [1:0] ds_sel;

    vme_signal_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
        .clock (clock), .reset (reset), .d (vme_dtack), .q (dtack_s)
    );
    vme_signal_sync #(.STAGES(SYNC_STAGES)) u_sync_berr (
        .clock (clock), .reset (reset), .d (vme_berr), .q (berr_s)
    );

    assign req_any   = (request_vme_a16 == ACTIVE) || (request_vme_a24 == ACTIVE) ||
                       (request_vme_a40 == ACTIVE);
    // LWORD only for an aligned long transfer on a 32-bit port.
    assign lword_sel = (PORT_WIDTH == 32 && cpu_siz == 2'b00 && cpu_address == 2'b00)
                       ? ACTIVE : INACTIVE;
    // Byte cycles pick one strobe by A0 (DS1 = even, DS0 = odd); all else uses both.
    assign ds_sel    = (cpu_siz == 2'b01) ? (cpu_address[0] ? 2'b10 : 2'b01) : 2'b00;

    // Next-state logic; attributes of the cycle are latched on entry to the phase that needs them.
    always_comb begin
        state_d = state_q;
        am_d    = am_q;
        write_d = write_q;
        lword_d = lword_q;
        ds_d    = ds_q;
        dir_d   = dir_q;
        setup_d = setup_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (cpu_as == ACTIVE && req_any && bus_acquired == ACTIVE) begin
                    state_d = ADDR;
                    am_d    = am_code(request_vme_a16 == ACTIVE, request_vme_a24 == ACTIVE, cpu_fc);
                    write_d = cpu_write;
                    lword_d = lword_sel;
                    setup_d = SETUP_LOAD;
                end
            end
            ADDR: begin
                // Leave as the counter reaches zero so AS falls AS_SETUP cycles after entry.
                if (cpu_as == INACTIVE) state_d = RECOVER;
                else if (setup_q <= 3'd1) begin
                    state_d = STROBE;
                    setup_d = '0;
                end else setup_d = setup_q - 3'd1;
            end
            STROBE: begin
                if (cpu_as == INACTIVE) state_d = RECOVER;
                else if (cpu_ds == ACTIVE) begin
                    state_d = WAIT_ACK;
                    ds_d    = ds_sel;
                    dir_d   = !cpu_write;
                    tmo_d   = TMO_LOAD;
                end
            end
            WAIT_ACK: begin
                // Bus error beats dtack; timeout fires as the counter reaches zero.
                if (cpu_as == INACTIVE)    state_d = RECOVER;
                else if (berr_s == ACTIVE) state_d = ERROR;
                else if (dtack_s == ACTIVE) state_d = ACK;
                else if (tmo_q <= 16'd1)   state_d = ERROR;
                if (tmo_q != '0) tmo_d = tmo_q - 16'd1;
            end
            ACK, ERROR: begin
                if (cpu_as == INACTIVE) state_d = RECOVER;
            end
            RECOVER: begin
                if (dtack_s == INACTIVE && berr_s == INACTIVE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: everything inactive unless the current phase drives it.
    always_comb begin
        vme_as          = INACTIVE;
        vme_ds          = 2'b11;
        vme_lword       = INACTIVE;
        vme_write       = INACTIVE;
        vme_address_mod = AM_IDLE;
        addr_oe         = INACTIVE;
        data_oe         = INACTIVE;
        data_dir        = 1'b0;
        cpu_dsack       = DSACK_NONE;
        cpu_berr        = INACTIVE;
        busy            = (state_q != IDLE);
        if (state_q inside {ADDR, STROBE, WAIT_ACK, ACK, ERROR}) begin
            addr_oe         = ACTIVE;
            vme_address_mod = am_q;
            vme_write       = write_q;
            vme_lword       = lword_q;
        end
        if (state_q inside {STROBE, WAIT_ACK, ACK, ERROR}) vme_as = ACTIVE;
        if (state_q inside {WAIT_ACK, ACK, ERROR}) begin
            vme_ds   = ds_q;
            data_oe  = ACTIVE;
            data_dir = dir_q;
        end
        if (state_q == ACK)   cpu_dsack = (lword_q == ACTIVE) ? DSACK_32 : DSACK_16;
        if (state_q == ERROR) cpu_berr  = ACTIVE;
    end

    // State and latched cycle attributes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            am_q    <= AM_IDLE;
            write_q <= INACTIVE;
            lword_q <= INACTIVE;
            ds_q    <= 2'b11;
            dir_q   <= 1'b0;
            setup_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            am_q    <= am_d;
            write_q <= write_d;
            lword_q <= lword_d;
            ds_q    <= ds_d;
            dir_q   <= dir_d;
            setup_q <= setup_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_vme_master_sequencer.sv
// Bench for vme_master_sequencer: a 16-bit and a 32-bit instance share all
// inputs; every response is checked against expectations derived from the
// VME cycle rules (AM table, strobe selection, latencies).
module tb_vme_master_sequencer;

    localparam int AS  = 3;
    localparam int TMO = 16;
    localparam int SS  = 2;
    localparam logic [17:0] RESET_VEC = {1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 1'b1,
                                         1'b1, 1'b1, 6'h3F, 1'b0, 1'b0};

    logic clock = 1'b0;
    logic reset;
    logic request_vme_a16, request_vme_a24, request_vme_a40, bus_acquired;
    logic cpu_as, cpu_ds, cpu_write;
    logic [1:0] cpu_siz, cpu_address;
    logic [2:0] cpu_fc;
    logic vme_dtack, vme_berr;

    logic [1:0] dsack [2];
    logic       berr_o [2];
    logic       vas [2];
    logic [1:0] vds [2];
    logic       lw [2];
    logic       vw [2];
    logic [5:0] am [2];
    logic       vbusy [2];
    logic       aoe [2];
    logic       doe [2];
    logic       ddir [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vme_master_sequencer #(.PORT_WIDTH(16), .AS_SETUP(AS), .TIMEOUT(TMO), .SYNC_STAGES(SS)) dut16 (
        .clock(clock), .reset(reset), .request_vme_a16(request_vme_a16),
        .request_vme_a24(request_vme_a24), .request_vme_a40(request_vme_a40),
        .bus_acquired(bus_acquired), .cpu_as(cpu_as), .cpu_ds(cpu_ds), .cpu_write(cpu_write),
        .cpu_siz(cpu_siz), .cpu_address(cpu_address), .cpu_fc(cpu_fc),
        .cpu_dsack(dsack[0]), .cpu_berr(berr_o[0]), .vme_as(vas[0]), .vme_ds(vds[0]),
        .vme_lword(lw[0]), .vme_write(vw[0]), .vme_address_mod(am[0]),
        .vme_dtack(vme_dtack), .vme_berr(vme_berr), .busy(vbusy[0]),
        .addr_oe(aoe[0]), .data_oe(doe[0]), .data_dir(ddir[0])
    );

    vme_master_sequencer #(.PORT_WIDTH(32), .AS_SETUP(AS), .TIMEOUT(TMO), .SYNC_STAGES(SS)) dut32 (
        .clock(clock), .reset(reset), .request_vme_a16(request_vme_a16),
        .request_vme_a24(request_vme_a24), .request_vme_a40(request_vme_a40),
        .bus_acquired(bus_acquired), .cpu_as(cpu_as), .cpu_ds(cpu_ds), .cpu_write(cpu_write),
        .cpu_siz(cpu_siz), .cpu_address(cpu_address), .cpu_fc(cpu_fc),
        .cpu_dsack(dsack[1]), .cpu_berr(berr_o[1]), .vme_as(vas[1]), .vme_ds(vds[1]),
        .vme_lword(lw[1]), .vme_write(vw[1]), .vme_address_mod(am[1]),
        .vme_dtack(vme_dtack), .vme_berr(vme_berr), .busy(vbusy[1]),
        .addr_oe(aoe[1]), .data_oe(doe[1]), .data_dir(ddir[1])
    );

    // ---------------- reference model ----------------
    // space: 0 = A16, 1 = A24, 2 = A40
    function automatic logic [5:0] exp_am(input int space, input logic [2:0] fc);
        logic [5:0] base;
        if (space == 2) return 6'h34;
        if (space == 0) return fc[2] ? 6'h2D : 6'h29;
        base = 6'h39;
        if (fc[2]) base = base + 6'd4;
        if (fc[1:0] == 2'b10) base = base + 6'd1;
        return base;
    endfunction

    function automatic logic [1:0] exp_ds(input logic [1:0] siz, input logic [1:0] ad);
        if (siz == 2'b01) return ad[0] ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_lw(input int pw, input logic [1:0] siz, input logic [1:0] ad);
        return (pw == 32 && siz == 2'b00 && ad == 2'b00) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [1:0] exp_dsack(input int pw, input logic [1:0] siz, input logic [1:0] ad);
        return (exp_lw(pw, siz, ad) == 1'b0) ? 2'b00 : 2'b01;
    endfunction

    function automatic logic [17:0] out_vec(input int d);
        return {vas[d], vds[d], lw[d], vw[d], dsack[d], berr_o[d], aoe[d], doe[d],
                am[d], ddir[d], vbusy[d]};
    endfunction

    task automatic idle_inputs();
        request_vme_a16 = 1'b1; request_vme_a24 = 1'b1; request_vme_a40 = 1'b1;
        bus_acquired = 1'b1; cpu_as = 1'b1; cpu_ds = 1'b1;
    endtask

    // mode: 0 dtack, 1 no response (timeout), 2 dtack+berr together, 3 berr only,
    //       4 reset during WAIT_ACK, 5 cpu_as released while strobing
    task automatic do_cycle(input int space, input logic [2:0] fc, input logic wr,
                            input logic [1:0] siz, input logic [1:0] ad,
                            input int dly, input int mode, input string tag);
        int cnt;
        int pw;
        logic [1:0] edsack;
        logic ebrr;
        @(negedge clock);
        cpu_fc = fc; cpu_write = wr; cpu_siz = siz; cpu_address = ad;
        request_vme_a16 = (space != 0); request_vme_a24 = (space != 1);
        request_vme_a40 = (space != 2);
        bus_acquired = 1'b0; cpu_as = 1'b0; cpu_ds = 1'b1;
        vme_dtack = 1'b1; vme_berr = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            pw = d ? 32 : 16;
            checks++;
            if ({vbusy[d], aoe[d], vas[d], am[d], vw[d], lw[d]} !==
                {1'b1, 1'b0, 1'b1, exp_am(space, fc), wr, exp_lw(pw, siz, ad)}) begin
                errors++;
                $display("FAIL %s addr_phase dut%0d busy/aoe/as/am/wr/lw got %b want %b", tag, d,
                    {vbusy[d], aoe[d], vas[d], am[d], vw[d], lw[d]},
                    {1'b1, 1'b0, 1'b1, exp_am(space, fc), wr, exp_lw(pw, siz, ad)});
            end
        end
        repeat (AS - 1) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vas[d] !== 1'b1) begin
                errors++; $display("FAIL %s as_setup dut%0d vme_as got %b want 1", tag, d, vas[d]);
            end
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vas[d], vds[d]} !== 3'b011) begin
                errors++; $display("FAIL %s as_assert dut%0d as/ds got %b want 011", tag, d, {vas[d], vds[d]});
            end
        end
        if (mode == 5) begin
            cpu_as = 1'b1;
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({vas[d], aoe[d], dsack[d], berr_o[d], vbusy[d]} !== 6'b111111) begin
                    errors++; $display("FAIL %s abort dut%0d as/aoe/dsack/berr/busy got %b want 111111",
                        tag, d, {vas[d], aoe[d], dsack[d], berr_o[d], vbusy[d]});
                end
            end
            idle_inputs();
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (out_vec(d) !== RESET_VEC) begin
                    errors++; $display("FAIL %s abort_idle dut%0d got %b want %b", tag, d, out_vec(d), RESET_VEC);
                end
            end
            return;
        end
        cpu_ds = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vds[d], doe[d], ddir[d], vas[d], dsack[d], berr_o[d]} !==
                {exp_ds(siz, ad), 1'b0, !wr, 1'b0, 2'b11, 1'b1}) begin
                errors++;
                $display("FAIL %s data_phase dut%0d ds/doe/dir/as/dsack/berr got %b want %b", tag, d,
                    {vds[d], doe[d], ddir[d], vas[d], dsack[d], berr_o[d]},
                    {exp_ds(siz, ad), 1'b0, !wr, 1'b0, 2'b11, 1'b1});
            end
        end
        if (mode == 4) begin
            repeat (2) @(negedge clock);
            reset = 1'b0;
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (out_vec(d) !== RESET_VEC) begin
                    errors++; $display("FAIL %s async_reset dut%0d got %b want %b", tag, d, out_vec(d), RESET_VEC);
                end
            end
            idle_inputs();
            @(negedge clock);
            reset = 1'b1;
            return;
        end
        if (mode != 1) begin
            repeat (dly) begin
                @(negedge clock);
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if ({dsack[d], berr_o[d]} !== 3'b111) begin
                        errors++; $display("FAIL %s pre_ack dut%0d dsack/berr got %b want 111", tag, d, {dsack[d], berr_o[d]});
                    end
                end
            end
            vme_dtack = (mode == 3) ? 1'b1 : 1'b0;
            vme_berr  = (mode == 0) ? 1'b1 : 1'b0;
        end
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (dsack[0] == 2'b11 && berr_o[0] == 1'b1 && cnt < 64);
        checks++;
        if (cnt != ((mode == 1) ? TMO : SS + 1)) begin
            errors++; $display("FAIL %s response_latency got %0d cycles want %0d", tag, cnt, (mode == 1) ? TMO : SS + 1);
        end
        for (int h = 0; h < 3; h++) begin
            if (h > 0) @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                pw = d ? 32 : 16;
                edsack = (mode == 0) ? exp_dsack(pw, siz, ad) : 2'b11;
                ebrr = (mode == 0);
                checks++;
                if ({dsack[d], berr_o[d], vas[d], vds[d]} !== {edsack, ebrr, 1'b0, exp_ds(siz, ad)}) begin
                    errors++;
                    $display("FAIL %s response dut%0d hold%0d dsack/berr/as/ds got %b want %b", tag, d, h,
                        {dsack[d], berr_o[d], vas[d], vds[d]}, {edsack, ebrr, 1'b0, exp_ds(siz, ad)});
                end
            end
        end
        idle_inputs();
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vas[d], vds[d], aoe[d], doe[d], am[d], dsack[d], berr_o[d], vbusy[d]} !==
                {1'b1, 2'b11, 1'b1, 1'b1, 6'h3F, 2'b11, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL %s recover dut%0d got %b want %b", tag, d,
                    {vas[d], vds[d], aoe[d], doe[d], am[d], dsack[d], berr_o[d], vbusy[d]},
                    {1'b1, 2'b11, 1'b1, 1'b1, 6'h3F, 2'b11, 1'b1, 1'b1});
            end
        end
        if (mode != 1) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (vbusy[d] !== 1'b1) begin
                    errors++; $display("FAIL %s hold_while_dtack dut%0d busy got %b want 1", tag, d, vbusy[d]);
                end
            end
            vme_dtack = 1'b1; vme_berr = 1'b1;
        end
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (vbusy[0] == 1'b1 && cnt < 64);
        checks++;
        if (cnt != ((mode == 1) ? 1 : SS + 1) || vbusy[1] !== 1'b0) begin
            errors++; $display("FAIL %s return_idle got %0d cycles busy32=%b want %0d cycles busy32=0",
                tag, cnt, vbusy[1], (mode == 1) ? 1 : SS + 1);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (out_vec(d) !== RESET_VEC) begin
                errors++; $display("FAIL reset_state dut%0d got %b want %b", d, out_vec(d), RESET_VEC);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        // Request without bus ownership must not start a cycle.
        cpu_as = 1'b0; request_vme_a24 = 1'b0; bus_acquired = 1'b1;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (out_vec(d) !== RESET_VEC) begin
                errors++; $display("FAIL no_bus_no_start dut%0d got %b want %b", d, out_vec(d), RESET_VEC);
            end
        end
        idle_inputs();
    endtask

    task automatic test_a24_sup_read();
        do_cycle(1, 3'b101, 1'b1, 2'b10, 2'b00, 5, 0, "a24_sup_word_read");
    endtask

    task automatic test_long_write();
        do_cycle(1, 3'b010, 1'b0, 2'b00, 2'b00, 2, 0, "a24_usr_prog_long_write");
    endtask

    task automatic test_byte_a16();
        do_cycle(0, 3'b001, 1'b0, 2'b01, 2'b01, 1, 0, "a16_usr_byte_odd");
        do_cycle(0, 3'b101, 1'b1, 2'b01, 2'b10, 0, 0, "a16_sup_byte_even");
    endtask

    task automatic test_timeout();
        do_cycle(2, 3'b110, 1'b1, 2'b10, 2'b00, 0, 1, "timeout");
    endtask

    task automatic test_berr_dtack();
        do_cycle(1, 3'b001, 1'b1, 2'b11, 2'b01, 3, 2, "berr_with_dtack");
        do_cycle(0, 3'b101, 1'b0, 2'b10, 2'b10, 0, 3, "berr_only");
    endtask

    task automatic test_reset_mid();
        do_cycle(1, 3'b101, 1'b1, 2'b00, 2'b00, 0, 4, "reset_mid_wait");
        do_cycle(1, 3'b101, 1'b1, 2'b00, 2'b00, 1, 0, "after_reset");
    endtask

    task automatic test_early_abort();
        do_cycle(2, 3'b001, 1'b1, 2'b10, 2'b00, 0, 5, "early_abort");
    endtask

    task automatic test_random();
        int space, mode;
        logic [2:0] fc;
        logic [1:0] siz, ad;
        logic wr;
        for (int i = 0; i < 24; i++) begin
            space = $urandom_range(0, 2);
            fc    = 3'($urandom_range(0, 7));
            siz   = 2'($urandom_range(0, 3));
            ad    = 2'($urandom_range(0, 3));
            wr    = 1'($urandom_range(0, 1));
            mode  = ($urandom_range(0, 3) == 0) ? 3 : 0;
            do_cycle(space, fc, wr, siz, ad, $urandom_range(0, 8), mode, "random");
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        cpu_write = 1'b1; cpu_siz = 2'b00; cpu_address = 2'b00; cpu_fc = 3'b000;
        vme_dtack = 1'b1; vme_berr = 1'b1;
        repeat (3) @(negedge clock);
        test_reset();
        test_a24_sup_read();
        test_long_write();
        test_byte_a16();
        test_timeout();
        test_berr_dtack();
        test_reset_mid();
        test_early_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
